// File: rtl/usb_rx_state_machine.sv
// rtl/usb_rx_state_machine.sv - USB2 PHY receive FSM: SYNC hunt, LSB-first byte assembly, UTMI RX outputs
// Registered outputs; a single next-state process computes every register update.
module usb_rx_state_machine #(
    parameter int FS_SYNC_ZEROS = 6,
    parameter int HS_SYNC_ZEROS = 12,
    parameter int MAX_BYTES     = 1027
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       rx_enable,
    input  logic       fs_mode,
    input  logic       bit_in,
    input  logic       bit_in_valid,
    input  logic       bit_stuff_error,
    input  logic       eop,
    output logic       rx_active,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_error
);

    localparam int BW = $clog2(MAX_BYTES + 1);
    localparam logic [BW-1:0] MAX_CNT = BW'(MAX_BYTES);
    localparam logic [4:0]    FS_THR  = 5'(FS_SYNC_ZEROS);
    localparam logic [4:0]    HS_THR  = 5'(HS_SYNC_ZEROS);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_DATA  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      zero_cnt_q, zero_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_active_q, rx_active_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_error_q, rx_error_d;

    logic [4:0]      sync_thr;
    logic [7:0]      shifted;

    assign sync_thr = fs_mode ? FS_THR : HS_THR;
    assign shifted  = {bit_in, shreg_q[7:1]};

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= ST_HUNT;
            zero_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_active_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            zero_cnt_q  <= zero_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_active_q <= rx_active_d;
            rx_valid_q  <= rx_valid_d;
            rx_error_q  <= rx_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        zero_cnt_d  = zero_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_active_d = rx_active_q;
        rx_valid_d  = 1'b0;
        rx_error_d  = 1'b0;

        if (!rx_enable) begin
            // Silent abort: TX turnaround or suspend is not a receive error.
            state_d     = ST_HUNT;
            zero_cnt_d  = '0;
            bit_cnt_d   = '0;
            byte_cnt_d  = '0;
            shreg_d     = '0;
            rx_active_d = 1'b0;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    if (eop) begin
                        zero_cnt_d = '0;
                    end else if (bit_in_valid) begin
                        if (!bit_in) begin
                            zero_cnt_d = (zero_cnt_q == 5'd31) ? 5'd31 : zero_cnt_q + 5'd1;
                        end else begin
                            zero_cnt_d = '0;
                            if (zero_cnt_q >= sync_thr) begin
                                state_d     = ST_DATA;
                                rx_active_d = 1'b1;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    zero_cnt_d = '0;
                    if (eop) begin
                        state_d     = ST_HUNT;
                        rx_active_d = 1'b0;
                        rx_error_d  = (bit_cnt_q != 3'd0);
                        bit_cnt_d   = '0;
                        byte_cnt_d  = '0;
                    end else if (bit_stuff_error) begin
                        state_d    = ST_ERROR;
                        rx_error_d = 1'b1;
                        bit_cnt_d  = '0;
                    end else if (bit_in_valid) begin
                        shreg_d   = shifted;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (byte_cnt_q == MAX_CNT) begin
                                state_d    = ST_ERROR;
                                rx_error_d = 1'b1;
                            end else begin
                                rx_data_d  = shifted;
                                rx_valid_d = 1'b1;
                                byte_cnt_d = byte_cnt_q + BW'(1);
                            end
                        end
                    end
                end
                ST_ERROR: begin
                    zero_cnt_d = '0;
                    if (eop) begin
                        state_d     = ST_HUNT;
                        rx_active_d = 1'b0;
                        bit_cnt_d   = '0;
                        byte_cnt_d  = '0;
                    end
                end
                default: begin
                    state_d     = ST_HUNT;
                    rx_active_d = 1'b0;
                end
            endcase
        end
    end

    assign rx_active = rx_active_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign rx_error  = rx_error_q;

endmodule

// File: doc/usb_rx_state_machine.md
Name: usb_rx_state_machine

Overview:
Receive-side counterpart of the TX state machine in the USB2 PHY digital block. Takes the NRZI-decoded, bit-unstuffed serial stream from the bit unstuffer and hunts for SYNC. It then assembles LSB-first bytes, presents them on the UTMI RX interface (rx_active / rx_valid / rx_data / rx_error) and terminates the packet on EOP. Supports FS and HS SYNC lengths and flags stuff errors, partial bytes and oversize packets.

Parameters:
FS_SYNC_ZEROS, 6, minimum run of decoded 0 bits before the terminating 1 to accept an FS SYNC (tolerates 1 lost bit).
HS_SYNC_ZEROS, 12, minimum zero run for an HS SYNC (31 nominal; tolerates up to 19 lost to squelch).
MAX_BYTES, 1027, maximum bytes per packet (PID + 1024 payload + CRC16); exceeding it is an error.

Ports:
clk  input  1  bit-rate clock
rst_b  input  1  asynchronous active-low reset
rx_enable  input  1  receive permitted; low while TX active or PHY suspended
fs_mode  input  1  1 = FS SYNC threshold, 0 = HS threshold
bit_in  input  1  decoded, unstuffed data bit
bit_in_valid  input  1  bit_in qualifier (low on stuff-bit removal cycles)
bit_stuff_error  input  1  unstuffer detected >6 consecutive ones (one-cycle pulse)
eop  input  1  end-of-packet / line-idle from the line-state decoder (one-cycle pulse)
rx_active  output  1  UTMI RxActive
rx_valid  output  1  UTMI RxValid, one-cycle pulse per byte
rx_data  output  8  UTMI DataOut, valid when rx_valid
rx_error  output  1  UTMI RxError, one-cycle pulse

Behaviour:
- Reset (rst_b low, async): state=HUNT; rx_active=0, rx_valid=0, rx_data=8'h00, rx_error=0; zero counter, bit counter and byte counter all 0.
- Single FSM. States: HUNT, DATA, ERROR. All outputs are registered.
- HUNT:
  - On each bit_in_valid with bit_in=0: increment the zero counter (5-bit, saturates at 31).
  - On bit_in=1: if zero counter >= threshold (FS_SYNC_ZEROS when fs_mode=1, else HS_SYNC_ZEROS), go to DATA and set rx_active=1 on the next edge. Otherwise clear the zero counter and stay in HUNT.
  - eop: clear the zero counter and stay in HUNT; rx_active stays 0.
- DATA:
  - Each bit_in_valid shifts bit_in into the MSB of an 8-bit shift register (LSB-first arrival) and increments a 3-bit bit counter.
  - On the 8th bit, rx_data is loaded with the assembled byte and rx_valid pulses on the next cycle. Latency is 1 cycle from the 8th-bit sample to rx_valid. The byte counter increments.
  - bit_in_valid low: no shift, no count.
- DATA, eop:
  - Bit counter = 0: rx_active drops on the next edge, then go to HUNT. No rx_error.
  - Bit counter != 0: discard the partial byte, pulse rx_error, drop rx_active on the same edge, then go to HUNT.
- DATA, bit_stuff_error: pulse rx_error, discard the partial byte, go to ERROR. rx_active stays 1.
- DATA, byte counter reaching MAX_BYTES with another 8th bit completing: that byte is not presented. Pulse rx_error and go to ERROR.
- ERROR: ignore bits, with no rx_valid. On eop, rx_active drops on the next edge and the FSM returns to HUNT.
- Simultaneous events:
  - eop has priority over bit_in_valid and bit_stuff_error in the same cycle; the bit is ignored.
  - bit_stuff_error has priority over a completing 8th bit; no rx_valid in that case.
- rx_valid is never asserted while rx_active=0. rx_valid and rx_error are never asserted together.
- rx_enable low (any state): on the next edge, force HUNT and clear all counters.
  - If rx_active was 1, it drops on that edge and no rx_error is generated.
  - rx_valid/rx_error are suppressed.
- fs_mode is sampled only in HUNT; changes during DATA/ERROR have no effect until the next packet.
- Back-to-back packets: the next SYNC is searched starting the cycle after the FSM re-enters HUNT.

Test Plan:
- FS packet: fs_mode=1; bits 0,0,0,0,0,0,0,1 then bytes 0xA5, 0xC3 LSB-first, then eop -> rx_active rises 1 cycle after the SYNC '1'. Two rx_valid pulses carry 0xA5 then 0xC3. rx_active falls 1 cycle after eop. rx_error never asserted.
- HS short SYNC: fs_mode=0; 12 zeros + 1 then byte 0x2D, eop -> one rx_valid with 0x2D. Repeat with 11 zeros + 1 -> rx_active stays 0, no rx_valid.
- FS too-short SYNC: 5 zeros + 1, then 6 zeros + 1, then 0x69 -> first run rejected, second accepted. One rx_valid with 0x69.
- Stuff error: bit_stuff_error after 3 bits of the 2nd byte (first byte 0xE1) -> rx_valid with 0xE1, then one rx_error pulse. rx_active stays 1 until eop, then falls; no further rx_valid.
- Residual bits and oversize:
  - eop after byte 0x5A plus 3 extra bits -> rx_valid 0x5A, one rx_error, rx_active falls.
  - With MAX_BYTES=4, send 5 bytes -> 4 rx_valid pulses, then rx_error.
- Abort paths: mid-byte rx_enable deassert -> rx_active falls next edge with no rx_error. Separately, rst_b low mid-packet -> all outputs 0 immediately. A following clean FS packet with 0x4B is received correctly.
